muldiv_sched: RTL and testbench

Iterative multiply/divide sequencer that sits beside the EX stage and owns the shared 32-bit shift-add multiplier / restoring divider. When EX decodes a multiply or divide (`CAL_MUL` asserted), this block accepts the operands and stalls the front of the pipeline while it iterates. It then presents a registered result for one cycle, and EX forwards that result in place of `ALU_out`. Pipeline flush on branch mispredict aborts any operation in flight.

---
 rtl/muldiv_if.sv | 16 +
 rtl/muldiv_sched.sv | 145 ++++++++++++++
 tb/tb_muldiv_sched.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/muldiv_if.sv
// Operand/result handshake between the EX stage and the mul/div sequencer.
interface muldiv_if #(
    parameter int WORD = 32
);
    logic            start;
    logic [2:0]      op;
    logic [WORD-1:0] src0;
    logic [WORD-1:0] src1;
    logic            flush;
    logic            stall;
    logic            done;
    logic [WORD-1:0] result;

    modport master (output start, op, src0, src1, flush, input stall, done, result);
    modport slave  (input start, op, src0, src1, flush, output stall, done, result);
endinterface

// File: rtl/muldiv_sched.sv
// Iterative shift-add multiplier / restoring divider sequencer beside EX.
// Define MULDIV_DIV_EN to build the divider; otherwise divide ops return 0 in one cycle.
//
// state | meaning
// IDLE  | waiting for start; captures operand magnitudes and sign flags
// BUSY  | one multiply or divide iteration per cycle, WORD cycles
// DONE  | result presented with done=1 for one cycle
module muldiv_sched #(
    parameter int WORD = 32
) (
    input  logic     clk,
    input  logic     rst,
    muldiv_if.slave  bus
);
    localparam int CNT_W = $clog2(WORD);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [2*WORD-1:0] acc;
    logic [WORD-1:0]   b_reg;
    logic [2:0]        op_r;
    logic              neg_a;
    logic              neg_b;

    logic              in_signed;
    logic              in_sa;
    logic              in_sb;
    logic [WORD-1:0]   mag_a;
    logic [WORD-1:0]   mag_b;
    logic [WORD:0]     mul_sum;
    logic [2*WORD-1:0] mul_next;
    logic [2*WORD-1:0] acc_next;
    logic [2*WORD-1:0] prod_s;
    logic [WORD-1:0]   mul_sel;
    logic [WORD-1:0]   fin_result;
    logic              last_iter;

    assign bus.stall = ~bus.flush & (((state == IDLE) & bus.start) | (state == BUSY));
    assign last_iter = (cnt == CNT_W'(WORD - 1));

    // 010, 110 and 111 are the unsigned ops; the reserved 011 behaves as MUL.W.
    assign in_signed = ~(bus.op[1] & (bus.op[2] | ~bus.op[0]));
    assign in_sa     = in_signed & bus.src0[WORD-1];
    assign in_sb     = in_signed & bus.src1[WORD-1];
    assign mag_a     = in_sa ? -bus.src0 : bus.src0;
    assign mag_b     = in_sb ? -bus.src1 : bus.src1;

    always_comb begin
        mul_sum  = {1'b0, acc[2*WORD-1:WORD]} + (acc[0] ? {1'b0, b_reg} : '0);
        mul_next = {mul_sum, acc[WORD-1:1]};
        prod_s   = (neg_a ^ neg_b) ? -mul_next : mul_next;
        mul_sel  = (op_r[1:0] == 2'b01 || op_r[1:0] == 2'b10) ? prod_s[2*WORD-1:WORD]
                                                             : prod_s[WORD-1:0];
    end

`ifdef MULDIV_DIV_EN
    logic [WORD:0]     trial;
    logic [2*WORD-1:0] div_next;
    logic [WORD-1:0]   quot_s;
    logic [WORD-1:0]   rem_s;

    // Remainder lives in the upper half, dividend/quotient shifts through the lower half.
    always_comb begin
        trial    = {acc[2*WORD-1:WORD], acc[WORD-1]} - {1'b0, b_reg};
        div_next = trial[WORD] ? {acc[2*WORD-2:0], 1'b0}
                               : {trial[WORD-1:0], acc[WORD-2:0], 1'b1};
        quot_s   = (neg_a ^ neg_b) ? -div_next[WORD-1:0] : div_next[WORD-1:0];
        rem_s    = neg_a ? -div_next[2*WORD-1:WORD] : div_next[2*WORD-1:WORD];
        acc_next = op_r[2] ? div_next : mul_next;
        fin_result = op_r[2] ? (op_r[0] ? rem_s : quot_s) : mul_sel;
    end
`else
    always_comb begin
        acc_next   = mul_next;
        fin_result = op_r[2] ? '0 : mul_sel;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            acc        <= '0;
            b_reg      <= '0;
            op_r       <= '0;
            neg_a      <= 1'b0;
            neg_b      <= 1'b0;
            bus.done   <= 1'b0;
            bus.result <= '0;
        end else if (bus.flush) begin
            state    <= IDLE;
            bus.done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        op_r  <= bus.op;
                        neg_a <= in_sa;
                        neg_b <= in_sb;
                        b_reg <= mag_b;
                        acc   <= {{WORD{1'b0}}, mag_a};
                        cnt   <= '0;
`ifdef MULDIV_DIV_EN
                        if (bus.op[2] && bus.src1 == '0) begin
                            bus.result <= bus.op[0] ? bus.src0 : '1;
                            bus.done   <= 1'b1;
                            state      <= DONE;
                        end else begin
                            state <= BUSY;
                        end
`else
                        if (bus.op[2]) begin
                            bus.result <= '0;
                            bus.done   <= 1'b1;
                            state      <= DONE;
                        end else begin
                            state <= BUSY;
                        end
`endif
                    end
                end
                BUSY: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    if (last_iter) begin
                        bus.result <= fin_result;
                        bus.done   <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_sched.sv
// Scoreboard bench for muldiv_sched: driver pushes expected results, monitor checks on done.
module tb_muldiv_sched;
`ifdef MULDIV_DIV_EN
    localparam bit DIV = 1'b1;
`else
    localparam bit DIV = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_res = 32'h0;

    muldiv_if #(.WORD(32)) bus ();
    muldiv_sched #(.WORD(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected done=0 (result %h)", bus.result);
            end else begin
                chk("result", bus.result, exp_q.pop_front());
            end
        end
    end

    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int exp_stall);
        int n = 0;
        bit seen = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.src0  = a;
        bus.src1  = b;
        exp_q.push_back(exp);
        last_res = exp;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (bus.done === 1'b1) begin
                seen = 1;
                chk("stall_in_done", 32'(bus.stall), 32'h0);
                bus.start = 1'b0;
                break;
            end
            if (bus.stall === 1'b1) n++;
            @(negedge clk);
        end
        if (!seen) begin
            bus.start = 1'b0;
            checks++;
            errors++;
            $display("FAIL timeout: got no done expected done within 100 cycles");
        end
        chk("stall_cycles", 32'(n), 32'(exp_stall));
    endtask

    initial begin
        bus.start = 1'b0;
        bus.op    = 3'b000;
        bus.src0  = '0;
        bus.src1  = '0;
        bus.flush = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_done", 32'(bus.done), 32'h0);
        chk("reset_result", bus.result, 32'h0);
        chk("reset_stall", 32'(bus.stall), 32'h0);
        rst = 1'b0;

        do_op(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        do_op(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
        do_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        do_op(3'b011, 32'd6, 32'd7, 32'd42, 33);
        do_op(3'b110, 32'd100, 32'd7, DIV ? 32'd14 : 32'd0, DIV ? 33 : 1);
        do_op(3'b111, 32'd100, 32'd7, DIV ? 32'd2 : 32'd0, DIV ? 33 : 1);
        do_op(3'b101, 32'hFFFF_FFF9, 32'd2, DIV ? 32'hFFFF_FFFF : 32'd0, DIV ? 33 : 1);
        do_op(3'b100, 32'hFFFF_FFF9, 32'd2, DIV ? 32'hFFFF_FFFD : 32'd0, DIV ? 33 : 1);
        do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, DIV ? 32'h8000_0000 : 32'd0, DIV ? 33 : 1);
        do_op(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, DIV ? 33 : 1);
        do_op(3'b100, 32'd5, 32'd0, DIV ? 32'hFFFF_FFFF : 32'd0, 1);
        do_op(3'b101, 32'd5, 32'd0, DIV ? 32'd5 : 32'd0, 1);
        do_op(3'b000, 32'd3, 32'd5, 32'd15, 33);

        // Flush at the 10th BUSY cycle; no result may appear and result holds.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 3'b000;
        bus.src0  = 32'd9;
        bus.src1  = 32'd9;
        repeat (10) @(negedge clk);
        bus.flush = 1'b1;
        #1;
        chk("flush_stall", 32'(bus.stall), 32'h0);
        @(negedge clk);
        bus.flush = 1'b0;
        bus.start = 1'b0;
        #1;
        chk("flush_result_hold", bus.result, last_res);
        chk("flush_no_done", 32'(bus.done), 32'h0);
        do_op(3'b000, 32'd11, 32'd12, 32'd132, 33);

        // Asynchronous reset in the middle of BUSY.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 3'b001;
        bus.src0  = 32'h1234_5678;
        bus.src1  = 32'h9ABC_DEF0;
        repeat (5) @(negedge clk);
        #2;
        rst = 1'b1;
        bus.start = 1'b0;
        #1;
        chk("rst_result", bus.result, 32'h0);
        chk("rst_done", 32'(bus.done), 32'h0);
        chk("rst_stall", 32'(bus.stall), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);

        do_op(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 33);
        do_op(3'b000, 32'h0001_0000, 32'h0001_0000, 32'd0, 33);

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
